// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for eight requesters sharing one resource.
// A single grant is held while its requester keeps requesting, up to HOLD_MAX
// consecutive cycles (0 = unlimited). Every release is followed by one idle
// cycle, and the search pointer then moves past the requester just served.
//
// Handshake: req is level-sensitive and is not latched. A requester owns the
// resource on every cycle where gnt[i] is high. It gives the resource up by
// dropping req[i], and the arbiter removes gnt on the following cycle.
module rr_arbiter_8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       dbg_state,
  output logic [2:0] dbg_ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] LP_HOLD = HOLD_MAX[7:0];

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;

  logic [15:0] w_dbl;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;
  logic [2:0]  w_winner;
  logic        w_timeout;
  logic        w_release;

  // Rotate req so r_ptr sits at bit 0, then pick the lowest set bit; the
  // winner is that offset added back onto r_ptr (wraps naturally in 3 bits).
  always_comb begin
    w_dbl    = {req, req} >> r_ptr;
    w_rot    = w_dbl[7:0];
    w_off    = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) w_off = 3'(k);
    end
    w_winner = r_ptr + w_off;
  end

  assign w_timeout = (HOLD_MAX != 0) && (r_hold_cnt == LP_HOLD);
  // Enable-low and timeout in the same cycle collapse into one release.
  assign w_release = !req[r_gnt_idx] || !en || w_timeout;

  // Two-state grant FSM with registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd0;
      r_hold_cnt  <= 8'd0;
      r_gnt       <= 8'h00;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && (req != 8'h00)) begin
            r_state     <= BUSY;
            r_gnt       <= 8'h01 << w_winner;
            r_gnt_idx   <= w_winner;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= 8'd1;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_state     <= IDLE;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx + 3'd1;
            r_hold_cnt  <= 8'd0;
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt  <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt       <= 8'h00;
          r_gnt_idx   <= 3'd0;
          r_gnt_valid <= 1'b0;
          r_hold_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign dbg_state = (r_state == BUSY);
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: three instances (HOLD_MAX = 4, 1, 0) share one
// stimulus stream. A behavioural model predicts each instance's next outputs
// when inputs are driven; predictions are queued and compared after the edge.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt_a [3];
  logic [2:0] idx_a [3];
  logic       vld_a [3];
  logic       st_a  [3];
  logic [2:0] ptr_a [3];

  rr_arbiter_8 #(.HOLD_MAX(4)) u_dut_h4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_a[0]), .gnt_idx(idx_a[0]), .gnt_valid(vld_a[0]),
    .dbg_state(st_a[0]), .dbg_ptr(ptr_a[0])
  );

  rr_arbiter_8 #(.HOLD_MAX(1)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_a[1]), .gnt_idx(idx_a[1]), .gnt_valid(vld_a[1]),
    .dbg_state(st_a[1]), .dbg_ptr(ptr_a[1])
  );

  rr_arbiter_8 #(.HOLD_MAX(0)) u_dut_h0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_a[2]), .gnt_idx(idx_a[2]), .gnt_valid(vld_a[2]),
    .dbg_state(st_a[2]), .dbg_ptr(ptr_a[2])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  int          hmax   [3] = '{4, 1, 0};
  int          m_busy [3] = '{0, 0, 0};
  int          m_ptr  [3] = '{0, 0, 0};
  int          m_hold [3] = '{0, 0, 0};
  int          m_idx  [3] = '{0, 0, 0};
  logic [7:0]  m_gnt  [3] = '{8'h00, 8'h00, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model of instance i by one clock using the current inputs.
  task automatic model_step(input int i);
    int win;
    bit rel;
    if (!rst_n) begin
      m_busy[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_idx[i] = 0; m_gnt[i] = 8'h00;
    end else if (m_busy[i] == 0) begin
      if (en && req != 8'h00) begin
        win = -1;
        for (int k = 0; k < 8; k++) begin
          if (win < 0 && req[(m_ptr[i] + k) % 8]) win = (m_ptr[i] + k) % 8;
        end
        m_busy[i] = 1;
        m_idx[i]  = win;
        m_gnt[i]  = 8'(1 << win);
        m_hold[i] = 1;
      end
    end else begin
      rel = (req[m_idx[i]] == 1'b0) || !en || (hmax[i] != 0 && m_hold[i] == hmax[i]);
      if (rel) begin
        m_busy[i] = 0;
        m_ptr[i]  = (m_idx[i] + 1) % 8;
        m_idx[i]  = 0;
        m_gnt[i]  = 8'h00;
        m_hold[i] = 0;
      end else if (m_hold[i] < 255) begin
        m_hold[i] = m_hold[i] + 1;
      end
    end
  endtask

  // One clock: predict, push, clock, pop, compare.
  task automatic step();
    logic [15:0] e;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      exp_q.push_back({m_busy[i][0], m_ptr[i][2:0], m_gnt[i], m_idx[i][2:0], m_busy[i][0]});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check($sformatf("u%0d_gnt", i),   32'(gnt_a[i]), 32'(e[11:4]));
      check($sformatf("u%0d_idx", i),   32'(idx_a[i]), 32'(e[3:1]));
      check($sformatf("u%0d_valid", i), 32'(vld_a[i]), 32'(e[0]));
      check($sformatf("u%0d_state", i), 32'(st_a[i]),  32'(e[15]));
      check($sformatf("u%0d_ptr", i),   32'(ptr_a[i]), 32'(e[14:12]));
    end
  endtask

  task automatic drive(input logic r_n, input logic e_n, input logic [7:0] r, input int cycles);
    rst_n = r_n;
    en    = e_n;
    req   = r;
    for (int c = 0; c < cycles; c++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    @(negedge clk);

    // Reset with all requesting, then rotation with everybody asking.
    drive(1'b0, 1'b1, 8'hFF, 2);
    check("rst_gnt_h1", 32'(gnt_a[1]), 32'h0);
    check("rst_valid_h1", 32'(vld_a[1]), 32'h0);
    drive(1'b1, 1'b1, 8'hFF, 1);
    check("first_grant_req0", 32'(gnt_a[1]), 32'h01);
    drive(1'b1, 1'b1, 8'hFF, 40);

    // Wrap and skip: serve requester 5 alone so ptr lands on 6, then 0 and 3.
    drive(1'b0, 1'b1, 8'h00, 1);
    drive(1'b1, 1'b1, 8'h20, 2);
    drive(1'b1, 1'b1, 8'h00, 1);
    check("ptr_after_5_h1", 32'(ptr_a[1]), 32'h6);
    drive(1'b1, 1'b1, 8'b0000_1001, 1);
    check("wrap_grant0_h1", 32'(gnt_a[1]), 32'h01);
    drive(1'b1, 1'b1, 8'b0000_1001, 6);

    // Voluntary release: requester 4 holds 3 cycles then drops.
    drive(1'b1, 1'b1, 8'h00, 2);
    drive(1'b1, 1'b1, 8'h10, 3);
    drive(1'b1, 1'b1, 8'hEF, 1);
    drive(1'b1, 1'b1, 8'hE0, 4);

    // Timeout: only requester 2, then 0 and 2 together.
    drive(1'b1, 1'b1, 8'h00, 2);
    drive(1'b1, 1'b1, 8'h04, 14);
    drive(1'b1, 1'b1, 8'h05, 14);

    // Enable drop mid-grant, requests held while disabled.
    drive(1'b1, 1'b1, 8'h40, 2);
    drive(1'b1, 1'b0, 8'h40, 4);
    drive(1'b1, 1'b1, 8'h40, 3);

    // Reset mid-grant.
    drive(1'b1, 1'b1, 8'h80, 2);
    drive(1'b0, 1'b1, 8'h80, 1);
    check("midrst_gnt_h0", 32'(gnt_a[2]), 32'h0);
    check("midrst_ptr_h0", 32'(ptr_a[2]), 32'h0);
    drive(1'b1, 1'b1, 8'h80, 3);

    // Random traffic with sticky requests so grants get held.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 7)] = 1'b0;
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
